// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: sequential PC requests, in-order responses buffered with their PCs, redirect flush.
// Optional IF_FETCH_PERF_EN adds saturating stall/flush performance counters.
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0]  DEPTH_C = DEPTH[CW:0];
   localparam logic [31:0]  NOP     = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q  [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];
   logic          req_fire, push, pop;
   logic [31:0]   redir_tgt;
   logic [CW:0]   credit;

   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   // Credit counts queued plus in-flight fetches, so every response is guaranteed a slot.
   assign credit         = {1'b0, count_q} + {1'b0, outst_q};
   assign imem_req_valid = !reset && !redirect_valid && (credit < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign if_valid       = (count_q != '0);
   assign if_pc          = pc_mem_q[rd_ptr_q];
   assign if_instruction = ins_mem_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      push       = 1'b0;
      pop        = 1'b0;
      if (redirect_valid) begin
         // Everything still in flight belongs to the old path and must be discarded.
         fetch_pc_d = redir_tgt;
         rsp_pc_d   = redir_tgt;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         outst_d    = outst_q - CW'(imem_rsp_valid);
         drop_d     = outst_d;
      end else begin
         pop = if_valid && id_ready;
         if (imem_rsp_valid) begin
            if (drop_q != '0) drop_d = drop_q - CW'(1);
            else              push   = 1'b1;
         end
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= NOP;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push) begin
            pc_mem_q[wr_ptr_q]  <= rsp_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rsp_data;
         end
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (if_valid && !id_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (redirect_valid && (flush_q != '1))        flush_q <= flush_q + 32'd1;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: memory model with variable latency and an expected-PC-stream model.
module tb_if_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        redirect_valid, id_ready, if_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, if_pc, if_instruction;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

   always #5 clk = ~clk;

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   int checks = 0, errors = 0;
   int cyc = 0, pops = 0;
   int lat_lo = 1, lat_hi = 1, rdy_pct = 100;
   int last_due = -1;
   logic [31:0] exp_pc, exp_req;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic        obs_ifv, obs_req;
   logic [31:0] obs_pc;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Instruction memory contents: bijective in the address, so a wrong PC/data pairing is visible.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // One clock cycle: drive memory, observe, update reference model, advance.
   task automatic step();
      logic acc;
      logic bound_ok;
      int   due;
      if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(mq_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      obs_ifv = if_valid;
      obs_pc  = if_pc;
      obs_req = imem_req_valid;
      acc     = imem_req_valid && imem_req_ready;
      if (!reset) begin
         if (redirect_valid) check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
         if (acc) check("req_addr", imem_req_addr, exp_req);
         if (if_valid && id_ready && !redirect_valid) begin
            check("pop_pc", if_pc, exp_pc);
            check("pop_instr", if_instruction, memf(exp_pc));
            exp_pc += 32'd4;
            pops++;
         end
      end
      if (imem_rsp_valid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (acc) begin
         due = cyc + int'($urandom_range(lat_hi, lat_lo));
         if (due <= last_due) due = last_due + 1;
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(due);
         last_due = due;
      end
      bound_ok = (mq_addr.size() <= DEPTH);
      check("outstanding_le_depth", 32'(bound_ok), 32'd1);
      if (reset) begin
         exp_pc  = RESET_PC;
         exp_req = RESET_PC;
         mq_addr.delete();
         mq_due.delete();
      end else if (redirect_valid) begin
         exp_pc  = redirect_pc & ~32'd3;
         exp_req = redirect_pc & ~32'd3;
      end else if (acc) begin
         exp_req += 32'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic found;
      int   rnd_pops;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      exp_pc         = RESET_PC;
      exp_req        = RESET_PC;
      @(posedge clk);
      #1;

      step();
      check("rst_req_valid", 32'(obs_req), 32'd0);
      step();
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instruction, 32'h0000_0013);

      // Reset release: first request at RESET_PC, stream from 2 cycles later at 1/cycle.
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 0) check("first_req_valid", 32'(obs_req), 32'd1);
         if (k < 2) check("early_if_valid", 32'(obs_ifv), 32'd0);
         else begin
            check("stream_valid", 32'(obs_ifv), 32'd1);
            check("stream_pc", obs_pc, 32'(4 * (k - 2)));
         end
      end

      // Stall at PC 8 for 5 cycles.
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (if_valid && if_pc == 32'd8) found = 1'b1;
         else step();
      end
      check("reach_pc8", 32'(found), 32'd1);
      id_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         check("stall_valid", 32'(obs_ifv), 32'd1);
         check("stall_pc_held", obs_pc, 32'd8);
         if (s >= 2) check("stall_no_req", 32'(obs_req), 32'd0);
      end
      id_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         step();
         check("resume_valid", 32'(obs_ifv), 32'd1);
         check("resume_pc", obs_pc, 32'(8 + 4 * s));
      end

      // Redirect with a queued backlog; unaligned target.
      id_ready = 1'b0;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_004B;
      step();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      step();
      check("redir_flush_valid", 32'(obs_ifv), 32'd0);
      check("redir_req_next", 32'(obs_req), 32'd1);
      step();
      check("redir_gap_valid", 32'(obs_ifv), 32'd0);
      step();
      check("redir_tgt_valid", 32'(obs_ifv), 32'd1);
      check("redir_tgt_pc", obs_pc, 32'h0000_0048);

      // Redirect coincident with pop and response, target near the top of the address space.
      for (int s = 0; s < 5; s++) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      step();
      check("coinc_flush_valid", 32'(obs_ifv), 32'd0);
      step();
      for (int s = 0; s < 4; s++) begin
         step();
         check("wrap_valid", 32'(obs_ifv), 32'd1);
         check("wrap_pc", obs_pc, 32'hFFFF_FFF8 + 32'(4 * s));
      end

      // Back-to-back redirects: the second wins.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      redirect_pc    = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (if_valid) found = 1'b1;
         else step();
      end
      check("b2b_found", 32'(found), 32'd1);
      check("b2b_pc", if_pc, 32'h0000_0200);

      // Random traffic: ready 50%, latency 1-3, random stalls, redirects and one reset.
      lat_lo   = 1;
      lat_hi   = 3;
      rdy_pct  = 50;
      rnd_pops = pops;
      for (int k = 0; k < 3000; k++) begin
         id_ready       = ($urandom_range(9) < 7);
         redirect_valid = ($urandom_range(99) < 4);
         redirect_pc    = $urandom();
         if (k == 1500) begin
            redirect_valid = 1'b0;
            do_reset();
            check("midrst_if_valid", 32'(if_valid), 32'd0);
            check("midrst_if_instr", if_instruction, 32'h0000_0013);
         end else begin
            step();
         end
      end
      redirect_valid = 1'b0;
      check("random_progress", 32'(pops - rnd_pops > 300), 32'd1);

`ifdef IF_FETCH_PERF_EN
      lat_lo  = 1;
      lat_hi  = 1;
      rdy_pct = 100;
      id_ready = 1'b1;
      do_reset();
      check("perf_rst_stall", perf_stall_cycles, 32'd0);
      check("perf_rst_flush", perf_flush_count, 32'd0);
      for (int s = 0; s < 4; s++) step();
      id_ready = 1'b0;
      for (int s = 0; s < 5; s++) step();
      id_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0000_0040;
         step();
         redirect_valid = 1'b0;
         step();
      end
      check("perf_stall", perf_stall_cycles, 32'd5);
      check("perf_flush", perf_flush_count, 32'd2);
      do_reset();
      check("perf_rst2_stall", perf_stall_cycles, 32'd0);
      check("perf_rst2_flush", perf_flush_count, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
